// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared state type, widths and constants for the crack scheduler
package crack_pkg;

  localparam int KEY_W = 24;
  localparam logic [1:0] ENG_PARITY = 2'b10;
  localparam logic [KEY_W-1:0] KEY_LIMIT = 24'hFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    RST_ENG,
    LAUNCH,
    RUN,
    STOP,
    DONE
  } sched_state_t;

  // Among engines reporting found, return the index holding the smaller key
  function automatic logic pick_winner(input logic [1:0] found,
                                       input logic [1:0][KEY_W-1:0] keys);
    logic [KEY_W-1:0] best;
    logic win;
    best = KEY_LIMIT;
    win = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (found[i] && keys[i] <= best) begin
        best = keys[i];
        win = i[0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/crack_sched_if.sv
// rtl/crack_sched_if.sv - host and engine-pair signal bundle for crack_sched
interface crack_sched_if #(parameter int CYC_W = 32);
  import crack_pkg::*;

  logic                  en;
  logic                  abort;
  logic                  rdy;
  logic                  key_valid;
  logic [KEY_W-1:0]      key;
  logic                  winner;
  logic [CYC_W-1:0]      cycles;
  logic [7:0]            pt_addr;
  logic [7:0]            pt_rddata;
  logic [1:0]            eng_rst_n;
  logic [1:0]            eng_start;
  logic [1:0]            eng_en;
  logic [1:0]            eng_stop;
  logic [1:0]            eng_rdy;
  logic [1:0]            eng_done;
  logic [1:0]            eng_found;
  logic [1:0][KEY_W-1:0] eng_key;
  logic [1:0][7:0]       eng_pt_addr;
  logic [1:0][7:0]       eng_pt_rddata;

  modport slave (
    input  en, abort, pt_addr, eng_rdy, eng_done, eng_found, eng_key, eng_pt_rddata,
    output rdy, key_valid, key, winner, cycles, pt_rddata,
           eng_rst_n, eng_start, eng_en, eng_stop, eng_pt_addr
  );

  modport master (
    output en, abort, pt_addr, eng_rdy, eng_done, eng_found, eng_key, eng_pt_rddata,
    input  rdy, key_valid, key, winner, cycles, pt_rddata,
           eng_rst_n, eng_start, eng_en, eng_stop, eng_pt_addr
  );

endinterface

// File: rtl/crack_pt_mux.sv
// rtl/crack_pt_mux.sv - routes host plaintext reads to the winning engine's memory
module crack_pt_mux
  import crack_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_winner,
  input  logic [7:0]      i_pt_addr,
  input  logic [1:0][7:0] i_eng_pt_rddata,
  output logic [1:0][7:0] o_eng_pt_addr,
  output logic [7:0]      o_pt_rddata
);

  logic r_winner_q;

  // Delayed select lines up with the one-cycle read latency of the engine memories
  always_ff @(posedge clk) begin
    if (rst) r_winner_q <= 1'b0;
    else     r_winner_q <= i_winner;
  end

  always_comb begin
    o_eng_pt_addr = '0;
    o_eng_pt_addr[i_winner] = i_pt_addr;
  end

  assign o_pt_rddata = i_eng_pt_rddata[r_winner_q];

endmodule

// File: rtl/crack_sched.sv
// rtl/crack_sched.sv - two-engine key-search scheduler: reset, launch, arbitrate, stop, readback
module crack_sched
  import crack_pkg::*;
#(
  parameter int CYC_W = 32
) (
  input logic          clk,
  input logic          rst,
  crack_sched_if.slave bus
);

  sched_state_t     r_state;
  logic             r_rst_cnt;
  logic [1:0]       r_exh;
  logic             r_rdy;
  logic             r_key_valid;
  logic             r_winner;
  logic [KEY_W-1:0] r_key;
  logic [CYC_W-1:0] r_cycles;
  logic [1:0]       r_eng_rst_n;
  logic [1:0]       r_eng_en;
  logic [1:0]       r_eng_stop;

  logic [1:0]       w_found;
  logic [1:0]       w_exh_next;
  logic             w_win;

  assign w_found    = bus.eng_done & bus.eng_found;
  assign w_exh_next = r_exh | (bus.eng_done & ~bus.eng_found);
  assign w_win      = pick_winner(w_found, bus.eng_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rst_cnt   <= 1'b0;
      r_exh       <= 2'b00;
      r_rdy       <= 1'b1;
      r_key_valid <= 1'b0;
      r_winner    <= 1'b0;
      r_key       <= '0;
      r_cycles    <= '0;
      r_eng_rst_n <= 2'b00;
      r_eng_en    <= 2'b00;
      r_eng_stop  <= 2'b00;
    end else begin
      r_eng_en    <= 2'b00;
      r_eng_stop  <= 2'b00;
      r_eng_rst_n <= 2'b11;
      if ((r_state == LAUNCH || r_state == RUN) && r_cycles != '1)
        r_cycles <= r_cycles + 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state     <= RST_ENG;
            r_rdy       <= 1'b0;
            r_cycles    <= '0;
            r_key_valid <= 1'b0;
            r_key       <= '0;
            r_winner    <= 1'b0;
            r_eng_rst_n <= 2'b00;
            r_rst_cnt   <= 1'b0;
          end
        end
        RST_ENG: begin
          r_rst_cnt <= 1'b1;
          if (!r_rst_cnt) r_eng_rst_n <= 2'b00;
          else            r_state     <= LAUNCH;
        end
        LAUNCH: begin
          if (bus.abort) begin
            r_eng_stop <= 2'b11;
            r_state    <= STOP;
          end else if (bus.eng_rdy == 2'b11) begin
            r_eng_en <= 2'b11;
            r_exh    <= 2'b00;
            r_state  <= RUN;
          end
        end
        RUN: begin
          // abort outranks a same-cycle find, and a find outranks exhaustion
          if (bus.abort) begin
            r_eng_stop <= 2'b11;
            r_state    <= STOP;
          end else if (|w_found) begin
            r_key       <= bus.eng_key[w_win];
            r_winner    <= w_win;
            r_key_valid <= 1'b1;
            r_eng_stop  <= w_win ? 2'b01 : 2'b10;
            r_state     <= STOP;
          end else begin
            r_exh <= w_exh_next;
            if (&w_exh_next) r_state <= DONE;
          end
        end
        STOP: r_state <= DONE;
        DONE: begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdy       = r_rdy;
  assign bus.key_valid = r_key_valid;
  assign bus.key       = r_key;
  assign bus.winner    = r_winner;
  assign bus.cycles    = r_cycles;
  assign bus.eng_rst_n = r_eng_rst_n;
  assign bus.eng_start = ENG_PARITY;
  assign bus.eng_en    = r_eng_en;
  assign bus.eng_stop  = r_eng_stop;

  crack_pt_mux u_pt_mux (
    .clk             (clk),
    .rst             (rst),
    .i_winner        (r_winner),
    .i_pt_addr       (bus.pt_addr),
    .i_eng_pt_rddata (bus.eng_pt_rddata),
    .o_eng_pt_addr   (bus.eng_pt_addr),
    .o_pt_rddata     (bus.pt_rddata)
  );

endmodule

// File: tb/tb_crack_sched.sv
// tb/tb_crack_sched.sv - randomized and directed bench for crack_sched against an outcome model
module tb_crack_sched;

  localparam int CW  = 8;
  localparam int BIG = 1000000;

  logic clk;
  logic rst;

  crack_sched_if #(.CYC_W(CW)) bus ();

  crack_sched #(.CYC_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  always @(posedge clk) begin
    bus.eng_pt_rddata[0] <= mem0[bus.eng_pt_addr[0]];
    bus.eng_pt_rddata[1] <= mem1[bus.eng_pt_addr[1]];
  end

  int total = 0;
  int bad   = 0;
  logic last_kv;
  logic last_w;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One search. Engine event times t0/t1 count from the first RUN cycle; ab counts from
  // the first LAUNCH cycle (-1 = no abort). The expected outcome is worked out first.
  task automatic run_search(input int lw, input int t0, input bit f0, input logic [23:0] k0,
                            input int t1, input bit f1, input logic [23:0] k1, input int ab);
    int L, c0, c1, cf, cx, c_end, kind, n, e, lat, exp_cyc;
    bit h0, h1, w;
    logic [23:0] exp_key;
    logic [1:0]  exp_stop;
    L  = lw + 1;
    c0 = L + t0;
    c1 = L + t1;
    cf = BIG;
    if (f0) cf = c0;
    if (f1 && c1 < cf) cf = c1;
    cx = (!f0 && !f1) ? ((c0 > c1) ? c0 : c1) : BIG;
    c_end = (cf <= cx) ? cf : cx;
    kind  = (cf <= cx) ? 1 : 2;
    if (ab >= 0 && ab <= c_end) begin
      c_end = ab;
      kind  = 0;
    end
    w = 1'b0;
    if (kind == 1) begin
      h0 = f0 && (c0 == c_end);
      h1 = f1 && (c1 == c_end);
      w  = h1 && (!h0 || k1 < k0);
    end
    exp_key  = (kind == 1) ? (w ? k1 : k0) : 24'h0;
    exp_stop = (kind == 0) ? 2'b11 : (kind == 1) ? (w ? 2'b01 : 2'b10) : 2'b00;
    exp_cyc  = (c_end + 1 > 255) ? 255 : c_end + 1;
    lat      = (kind == 2) ? 2 : 3;

    n = 0;
    while (bus.rdy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("rdy_before_en", bus.rdy, 1);
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    check_eq("rst_n_first", bus.eng_rst_n, 2'b00);
    check_eq("cycles_clear", bus.cycles, 0);
    check_eq("kv_clear", bus.key_valid, 0);
    tick();
    check_eq("rst_n_second", bus.eng_rst_n, 2'b00);
    tick();
    check_eq("rst_n_release", bus.eng_rst_n, 2'b11);

    for (int c = 0; c <= c_end; c++) begin
      bus.eng_rdy    = (c >= lw) ? 2'b11 : 2'b00;
      bus.abort      = (c == ab);
      bus.eng_done   = {c == c1, c == c0};
      bus.eng_found  = 2'($urandom);
      if (c == c0) bus.eng_found[0] = f0;
      if (c == c1) bus.eng_found[1] = f1;
      bus.eng_key[0] = (c == c0) ? k0 : 24'($urandom);
      bus.eng_key[1] = (c == c1) ? k1 : 24'($urandom);
      if (c == L) check_eq("eng_en_pulse", bus.eng_en, 2'b11);
      tick();
    end
    bus.abort     = 1'b0;
    bus.eng_done  = 2'b00;
    bus.eng_found = 2'b00;

    e = 1;
    check_eq("eng_stop", bus.eng_stop, exp_stop);
    check_eq("key_valid", bus.key_valid, kind == 1);
    check_eq("key", bus.key, exp_key);
    check_eq("winner", bus.winner, w);
    tick();
    e = 2;
    check_eq("eng_stop_off", bus.eng_stop, 2'b00);
    while (bus.rdy !== 1'b1 && e < 10) begin
      tick();
      e++;
    end
    check_eq("rdy_latency", e, lat);
    check_eq("cycles", bus.cycles, exp_cyc);
    check_eq("key_hold", bus.key, exp_key);
    check_eq("kv_hold", bus.key_valid, kind == 1);
    last_kv = (kind == 1);
    last_w  = w;
  endtask

  task automatic pt_read(input logic [7:0] a);
    bus.pt_addr = a;
    #1;
    check_eq("pt_addr_win", bus.eng_pt_addr[last_w], a);
    check_eq("pt_addr_lose", bus.eng_pt_addr[!last_w], 0);
    tick();
    check_eq("pt_rddata", bus.pt_rddata, last_w ? mem1[a] : mem0[a]);
  endtask

  task automatic reset_mid_run();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    tick();
    tick();
    bus.eng_rdy = 2'b11;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_rdy", bus.rdy, 1);
    check_eq("mid_rst_rst_n", bus.eng_rst_n, 2'b00);
    check_eq("mid_rst_cycles", bus.cycles, 0);
    check_eq("mid_rst_eng_en", bus.eng_en, 0);
    check_eq("mid_rst_stop", bus.eng_stop, 0);
    rst = 1'b0;
    tick();
    check_eq("mid_rst_release", bus.eng_rst_n, 2'b11);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ka, kb;
    int lw, ta, tb, ab;
    bit fa, fb;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    rst = 1'b1;
    bus.en = 1'b0;
    bus.abort = 1'b0;
    bus.pt_addr = 8'h00;
    bus.eng_rdy = 2'b00;
    bus.eng_done = 2'b00;
    bus.eng_found = 2'b00;
    bus.eng_key = '0;
    last_kv = 1'b0;
    last_w = 1'b0;
    tick();
    tick();
    check_eq("rst_rdy", bus.rdy, 1);
    check_eq("rst_kv", bus.key_valid, 0);
    check_eq("rst_key", bus.key, 0);
    check_eq("rst_winner", bus.winner, 0);
    check_eq("rst_cycles", bus.cycles, 0);
    check_eq("rst_eng_rst_n", bus.eng_rst_n, 2'b00);
    check_eq("rst_eng_en", bus.eng_en, 0);
    check_eq("rst_eng_stop", bus.eng_stop, 0);
    check_eq("rst_eng_start", bus.eng_start, 2'b10);
    check_eq("rst_pt_addr", bus.eng_pt_addr, 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_rst_n", bus.eng_rst_n, 2'b11);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("idle_abort_ignored", bus.rdy, 1);

    run_search(1, 100, 0, 24'h000000, 40, 1, 24'h00A3F1, -1);
    for (int a = 0; a < 4; a++) pt_read(8'(a));
    run_search(0, 12, 1, 24'h000010, 12, 1, 24'h000007, -1);
    run_search(2, 20, 0, 24'h000000, 35, 0, 24'h000001, -1);
    run_search(0, 15, 1, 24'h001234, 50, 0, 24'h000001, 16);
    run_search(3, 10, 1, 24'h000002, 10, 1, 24'h000003, 1);
    run_search(1, 8, 0, 24'h000000, 8, 1, 24'hFFFFFF, -1);
    run_search(0, 300, 0, 24'h000000, 290, 0, 24'h000001, -1);
    reset_mid_run();
    run_search(0, 5, 1, 24'h0000AA, 9, 0, 24'h000001, -1);
    for (int a = 0; a < 4; a++) pt_read(8'(a));

    for (int s = 0; s < 30; s++) begin
      lw = $urandom_range(3);
      ta = $urandom_range(30);
      tb = $urandom_range(30);
      fa = 1'($urandom);
      fb = 1'($urandom);
      ka = 24'($urandom) & 24'hFFFFFE;
      kb = 24'($urandom) | 24'h000001;
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(lw + 31)) : -1;
      run_search(lw, ta, fa, ka, tb, fb, kb, ab);
      if (last_kv) pt_read(8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
